ibex_counter_bank: RTL and testbench



---
 rtl/ibex_counter_bank.sv | 160 ++++++++++++++++
 tb/tb_ibex_counter_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_counter_bank.sv
// Memory-mapped bank of event counters with CTRL/OVF registers on the counter req/gnt/rvalid bus.
// Optional shadow snapshot registers enabled by defining IBEX_COUNTER_BANK_SNAPSHOT_EN.
module ibex_counter_bank #(
  parameter int unsigned NUM_COUNTERS = 8,
  parameter int unsigned COUNTER_W    = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    counter_req_i,
  output logic                    counter_gnt_o,
  output logic                    counter_rvalid_o,
  input  logic                    counter_we_i,
  input  logic [31:0]             counter_addr_i,
  input  logic [31:0]             counter_wdata_i,
  output logic [31:0]             counter_rdata_o,
  output logic                    counter_err_o,
  input  logic [NUM_COUNTERS-1:0] event_i
);

  localparam int unsigned DATA_W = 32;

  logic [DATA_W-1:0]                         off;
  logic                                      ctrl_hit;
  logic                                      ovf_hit;
  logic                                      snap_hit;
  logic [NUM_COUNTERS-1:0]                   cnt_hit;
  logic                                      dec_err;
  logic                                      wr_en;
  logic [DATA_W-1:0]                         rd_val;

  logic [NUM_COUNTERS-1:0]                   ctrl_q, ctrl_d;
  logic [NUM_COUNTERS-1:0]                   ovf_q, ovf_d;
  logic [NUM_COUNTERS-1:0]                   wrap;
  logic [NUM_COUNTERS-1:0][COUNTER_W-1:0]    cnt_q, cnt_d;

  logic                                      rvalid_q;
  logic                                      err_q;
  logic [DATA_W-1:0]                         rdata_q;

  // Always ready: grant mirrors the request.
  assign counter_gnt_o    = counter_req_i;
  assign counter_rvalid_o = rvalid_q;
  assign counter_rdata_o  = rdata_q;
  assign counter_err_o    = err_q;

  // Address decode relative to the window base.
  always_comb begin
    off      = counter_addr_i - BASE_ADDR;
    ctrl_hit = (off == 32'h0000_0000);
    ovf_hit  = (off == 32'h0000_0004);
`ifdef IBEX_COUNTER_BANK_SNAPSHOT_EN
    snap_hit = (off == 32'h0000_0008);
`else
    snap_hit = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
      cnt_hit[i] = (off == 32'(32'h10 + 32'(4 * i)));
    end
    dec_err = (counter_addr_i[1:0] != 2'b00) ||
              !(ctrl_hit || ovf_hit || snap_hit || (|cnt_hit));
    wr_en   = counter_req_i && counter_we_i && !dec_err;
  end

`ifdef IBEX_COUNTER_BANK_SNAPSHOT_EN
  logic [NUM_COUNTERS-1:0][COUNTER_W-1:0] shd_q, shd_d;

  // Snapshot copies pre-increment live values; counter writes land in both copies.
  always_comb begin
    shd_d = shd_q;
    for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
      if (wr_en && snap_hit) begin
        shd_d[i] = cnt_q[i];
      end
      if (wr_en && cnt_hit[i]) begin
        shd_d[i] = counter_wdata_i[COUNTER_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shd_q <= '0;
    end else begin
      shd_q <= shd_d;
    end
  end
`endif

  // Read mux reflects register state of the grant cycle.
  always_comb begin
    rd_val = '0;
    if (ctrl_hit) begin
      rd_val = DATA_W'(ctrl_q);
    end
    if (ovf_hit) begin
      rd_val = DATA_W'(ovf_q);
    end
    for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
      if (cnt_hit[i]) begin
`ifdef IBEX_COUNTER_BANK_SNAPSHOT_EN
        rd_val = DATA_W'(shd_q[i]);
`else
        rd_val = DATA_W'(cnt_q[i]);
`endif
      end
    end
  end

  // Bus writes win over same-cycle increments; a new wrap wins over W1C.
  always_comb begin
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    wrap   = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
      if (wr_en && cnt_hit[i]) begin
        cnt_d[i] = counter_wdata_i[COUNTER_W-1:0];
      end else if (event_i[i] && ctrl_q[i]) begin
        cnt_d[i] = cnt_q[i] + COUNTER_W'(1);
        wrap[i]  = &cnt_q[i];
      end
    end
    if (wr_en && ctrl_hit) begin
      ctrl_d = counter_wdata_i[NUM_COUNTERS-1:0];
    end
    if (wr_en && ovf_hit) begin
      ovf_d = ovf_q & ~counter_wdata_i[NUM_COUNTERS-1:0];
    end
    ovf_d = ovf_d | wrap;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      ovf_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  // One response per grant; rdata/err hold between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= counter_req_i;
      if (counter_req_i) begin
        err_q   <= dec_err;
        rdata_q <= (dec_err || counter_we_i) ? '0 : rd_val;
      end
    end
  end

endmodule

// File: tb/tb_ibex_counter_bank.sv
// Directed plus randomized bench for ibex_counter_bank against a cycle-level behavioural model.
module tb_ibex_counter_bank;

  localparam int unsigned N    = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MASK = (1 << N) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          counter_req_i;
  logic          counter_gnt_o;
  logic          counter_rvalid_o;
  logic          counter_we_i;
  logic [31:0]   counter_addr_i;
  logic [31:0]   counter_wdata_i;
  logic [31:0]   counter_rdata_o;
  logic          counter_err_o;
  logic [N-1:0]  event_i;

  ibex_counter_bank #(.NUM_COUNTERS(N), .COUNTER_W(32), .BASE_ADDR(BASE)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .counter_req_i    (counter_req_i),
    .counter_gnt_o    (counter_gnt_o),
    .counter_rvalid_o (counter_rvalid_o),
    .counter_we_i     (counter_we_i),
    .counter_addr_i   (counter_addr_i),
    .counter_wdata_i  (counter_wdata_i),
    .counter_rdata_o  (counter_rdata_o),
    .counter_err_o    (counter_err_o),
    .event_i          (event_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int unsigned m_cnt [N];
  int unsigned m_shd [N];
  int unsigned m_ctrl;
  int unsigned m_ovf;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] last_rdata;
  logic        last_err;

  logic [31:0] addr_tab [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                                 32'h18, 32'h1C, 32'h2C, 32'h30, 32'h40, 32'h12};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_cnt[i] = 0;
      m_shd[i] = 0;
    end
    m_ctrl  = 0;
    m_ovf   = 0;
    m_rdata = '0;
    m_err   = 1'b0;
  endtask

  // One bus cycle: drive, check gnt, advance model, check response after the edge.
  task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [N-1:0] ev);
    int unsigned off;
    int          idx;
    int          wr_idx;
    logic        e_err;
    logic [31:0] e_rd;
    int unsigned clr;
    int unsigned wraps;
    int unsigned n_cnt [N];
    counter_req_i   = req;
    counter_we_i    = we;
    counter_addr_i  = addr;
    counter_wdata_i = wdata;
    event_i         = ev;
    #1;
    check("gnt", 32'(counter_gnt_o), 32'(req));

    off    = addr - BASE;
    e_err  = 1'b1;
    e_rd   = '0;
    idx    = -1;
    wr_idx = -1;
    if (addr[1:0] == 2'b00) begin
      if (off == 0) begin
        e_err = 1'b0; e_rd = m_ctrl;
      end else if (off == 4) begin
        e_err = 1'b0; e_rd = m_ovf;
      end else if (off == 8) begin
`ifdef IBEX_COUNTER_BANK_SNAPSHOT_EN
        e_err = 1'b0; e_rd = '0;
`endif
      end else if (off >= 16 && off < 16 + 4 * N) begin
        e_err = 1'b0;
        idx   = int'((off - 16) / 4);
`ifdef IBEX_COUNTER_BANK_SNAPSHOT_EN
        e_rd  = m_shd[idx];
`else
        e_rd  = m_cnt[idx];
`endif
      end
    end
    if (we || e_err) e_rd = '0;
    if (req) begin
      m_rdata = e_rd;
      m_err   = e_err;
    end

    clr = 0;
    if (req && we && !e_err) begin
      if (off == 0) m_ctrl = m_ctrl; // applied after increments below
      if (off == 4) clr = wdata & MASK;
      if (idx >= 0) wr_idx = idx;
`ifdef IBEX_COUNTER_BANK_SNAPSHOT_EN
      if (off == 8) for (int i = 0; i < int'(N); i++) m_shd[i] = m_cnt[i];
      if (idx >= 0) m_shd[idx] = wdata;
`endif
    end
    wraps = 0;
    for (int i = 0; i < int'(N); i++) begin
      n_cnt[i] = m_cnt[i];
      if (i == wr_idx) begin
        n_cnt[i] = wdata;
      end else if (m_ctrl[i] && ev[i]) begin
        if (m_cnt[i] == 32'hFFFF_FFFF) begin
          n_cnt[i] = 0;
          wraps = wraps | (32'd1 << i);
        end else begin
          n_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    for (int i = 0; i < int'(N); i++) m_cnt[i] = n_cnt[i];
    m_ovf = (m_ovf & ~clr) | wraps;
    if (req && we && !e_err && off == 0) m_ctrl = wdata & MASK;

    @(posedge clk_i);
    #1;
    check("rvalid", 32'(counter_rvalid_o), 32'(req));
    check("rdata", counter_rdata_o, m_rdata);
    check("err", 32'(counter_err_o), 32'(m_err));
    last_rdata = counter_rdata_o;
    last_err   = counter_err_o;
  endtask

  initial begin
    rst_i           = 1'b1;
    counter_req_i   = 1'b0;
    counter_we_i    = 1'b0;
    counter_addr_i  = '0;
    counter_wdata_i = '0;
    event_i         = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rvalid", 32'(counter_rvalid_o), 32'd0);
    check("rst_rdata", counter_rdata_o, 32'd0);
    check("rst_err", 32'(counter_err_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset-state read of counter 0
    cycle(1, 0, 32'h10, 0, '0);
    check("rd_cnt0_reset", last_rdata, 32'd0);

    // Enable counter 0, count 5 events; counter 1 stays disabled
    cycle(1, 1, 32'h00, 32'h1, '0);
    repeat (5) cycle(0, 0, 0, 0, 8'h01);
    cycle(1, 0, 32'h10, 0, '0);
    check("cnt0_five", last_rdata, 32'd5);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, (k % 2 == 0) ? 8'h02 : 8'h00);
    cycle(1, 0, 32'h14, 0, 8'h02);
    check("cnt1_disabled", last_rdata, 32'd0);

    // Wrap sets OVF, W1C clears, W1C colliding with a wrap keeps it set
    cycle(1, 1, 32'h10, 32'hFFFF_FFFE, '0);
    repeat (3) cycle(0, 0, 0, 0, 8'h01);
    cycle(1, 0, 32'h10, 0, '0);
    check("cnt0_wrapped", last_rdata, 32'd1);
    cycle(1, 0, 32'h04, 0, '0);
    check("ovf_set", last_rdata, 32'd1);
    cycle(1, 1, 32'h04, 32'h1, '0);
    cycle(1, 0, 32'h04, 0, '0);
    check("ovf_cleared", last_rdata, 32'd0);
    cycle(1, 1, 32'h10, 32'hFFFF_FFFF, '0);
    cycle(1, 1, 32'h04, 32'h1, 8'h01);
    cycle(1, 0, 32'h04, 0, '0);
    check("ovf_set_wins", last_rdata, 32'd1);

    // Error addresses leave state untouched
    cycle(1, 0, 32'h12, 0, '0);
    check("err_misaligned", 32'(last_err), 32'd1);
    cycle(1, 0, 32'h30, 0, '0);
    check("err_idx8", 32'(last_err), 32'd1);
    cycle(1, 1, 32'h40, 32'hFF, '0);
    check("err_wr40", 32'(last_err), 32'd1);
    cycle(1, 1, 32'h0C, 32'hFF, '0);
    cycle(1, 0, 32'h00, 0, '0);
    check("ctrl_unchanged", last_rdata, 32'd1);

    // Back-to-back write then read; write beats same-cycle event
    cycle(1, 1, 32'h10, 32'h100, 8'h01);
    cycle(1, 0, 32'h10, 0, '0);
    check("b2b_rd", last_rdata, 32'h100);

    // Snapshot behaviour, or SNAP as an error address
`ifdef IBEX_COUNTER_BANK_SNAPSHOT_EN
    cycle(1, 1, 32'h10, 32'd7, '0);
    cycle(1, 1, 32'h08, 32'hDEAD, '0);
    repeat (4) cycle(0, 0, 0, 0, 8'h01);
    cycle(1, 0, 32'h10, 0, '0);
    check("snap_shadow", last_rdata, 32'd7);
`else
    cycle(1, 1, 32'h08, 32'hDEAD, '0);
    check("snap_err", 32'(last_err), 32'd1);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = addr_tab[$urandom_range(0, 11)];
      d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      if (a == 32'h00 && $urandom_range(0, 1) == 1) d = 32'hFF;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, d, N'($urandom));
    end

    // Reset while a request is pending: no response after release
    counter_req_i  = 1'b1;
    counter_we_i   = 1'b0;
    counter_addr_i = 32'h10;
    #2;
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    check("rst_mid_rvalid", 32'(counter_rvalid_o), 32'd0);
    rst_i = 1'b0;
    cycle(0, 0, 0, 0, '0);
    cycle(1, 0, 32'h10, 0, '0);
    check("post_rst_cnt0", last_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
